fruit_projectile: RTL and testbench

Parametrised fruit trajectory engine for the slicing game: on a launch handshake it flies one fruit along a gravity-driven parabola in sub-pixel fixed point, bounces it off the side walls, and retires it when sliced or when it falls offstage. One instance per fruit slot. It sits between the game-control FSM, which issues launches and slice hits, and the colour mapper, which consumes `fruitX`, `fruitY` and `fruitS`.

---
 rtl/fruit_pkg.sv | 17 +
 rtl/fruit_axis.sv | 72 +++++++
 rtl/fruit_projectile.sv | 147 ++++++++++++++
 tb/tb_fruit_projectile.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fruit_pkg.sv
// Shared state encoding, fixed-point scale and default playfield geometry
// for the fruit trajectory engine.
package fruit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        SLICED = 2'd2
    } fruit_state_e;

    localparam int FRAC_BITS_DEF = 4;
    localparam int X_MIN_DEF     = 0;
    localparam int X_MAX_DEF     = 639;
    localparam int Y_LAUNCH_DEF  = 500;
    localparam int Y_OFF_DEF     = 560;

endpackage

// File: rtl/fruit_axis.sv
// One-axis fixed-point integrator: pos += old vel, then vel = min(vel + ACCEL, V_TERM),
// with optional clamp-and-reflect against [LO_PX, HI_PX] on the integer position.
module fruit_axis #(
    parameter int POS_W     = 15,
    parameter int VW        = 11,
    parameter int FRAC_BITS = 4,
    parameter int ACCEL     = 0,
    parameter int V_TERM    = 1023,
    parameter bit BOUNCE    = 1'b0,
    parameter int LO_PX     = 0,
    parameter int HI_PX     = 0,
    parameter int RST_PX    = 0
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic                    halt,
    input  logic                    step,
    input  logic signed [POS_W-1:0] load_pos,
    input  logic signed [VW-1:0]    load_vel,
    output logic signed [POS_W-1:0] pos,
    output logic signed [VW-1:0]    vel
);
    localparam int IW = POS_W - FRAC_BITS;
    localparam logic signed [POS_W-1:0] LO_FP  = POS_W'(LO_PX * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] HI_FP  = POS_W'(HI_PX * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] RST_FP = POS_W'(RST_PX * (2 ** FRAC_BITS));
    localparam logic signed [IW-1:0]    LO_I   = IW'(LO_PX);
    localparam logic signed [IW-1:0]    HI_I   = IW'(HI_PX);
    localparam logic signed [VW:0]      ACC_W  = (VW + 1)'(ACCEL);
    localparam logic signed [VW:0]      TERM_W = (VW + 1)'(V_TERM);

    logic signed [POS_W-1:0] pos_sum, pos_n;
    logic signed [IW-1:0]    pos_int;
    logic signed [VW:0]      vel_acc;
    logic signed [VW-1:0]    vel_step, vel_n;

    always_comb begin
        pos_sum  = pos + {{(POS_W - VW){vel[VW-1]}}, vel};
        pos_int  = pos_sum[POS_W-1:FRAC_BITS];
        // one guard bit so the terminal-velocity compare cannot wrap
        vel_acc  = {vel[VW-1], vel} + ACC_W;
        vel_step = (vel_acc > TERM_W) ? TERM_W[VW-1:0] : vel_acc[VW-1:0];
        pos_n    = pos_sum;
        vel_n    = vel_step;
        if (BOUNCE) begin
            if (pos_int < LO_I) begin
                pos_n = LO_FP;
                vel_n = -vel_step;
            end else if (pos_int > HI_I) begin
                pos_n = HI_FP;
                vel_n = -vel_step;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pos <= RST_FP;
            vel <= '0;
        end else if (load) begin
            pos <= load_pos;
            vel <= load_vel;
        end else if (halt) begin
            vel <= '0;
        end else if (step) begin
            pos <= pos_n;
            vel <= vel_n;
        end
    end

endmodule

// File: rtl/fruit_projectile.sv
// Single fruit slot: launches on handshake, flies a gravity parabola with wall bounces,
// and retires on slice (after a hold) or when it drops offstage.
//   state  | meaning
//   IDLE   | parked, waiting for launch_req
//   FLIGHT | integrating motion each frame
//   SLICED | frozen, counting down the hold before release
module fruit_projectile
    import fruit_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int VEL_W        = 10,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int GRAVITY      = 4,
    parameter int VY_TERM      = 160,
    parameter int Y_LAUNCH     = Y_LAUNCH_DEF,
    parameter int Y_OFF        = Y_OFF_DEF,
    parameter int X_MIN        = X_MIN_DEF,
    parameter int X_MAX        = X_MAX_DEF,
    parameter int SIZE         = 15,
    parameter int SLICE_FRAMES = 8
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               launch_req,
    input  logic [COORD_W-1:0] launch_x,
    input  logic [VEL_W-1:0]   launch_vy,
    input  logic [VEL_W-1:0]   launch_vx,
    input  logic               launch_neg,
    input  logic               slice,
    output logic               launch_ack,
    output logic               active,
    output logic               sliced,
    output logic               hit_done,
    output logic               missed,
    output logic [COORD_W-1:0] fruitX,
    output logic [COORD_W-1:0] fruitY,
    output logic [COORD_W-1:0] fruitS
);
    localparam int POS_W = COORD_W + 1 + FRAC_BITS;
    localparam int VW    = VEL_W + 1;
    localparam int IW    = COORD_W + 1;
    localparam int CNT_W = (SLICE_FRAMES > 1) ? $clog2(SLICE_FRAMES) : 1;
    localparam logic signed [IW-1:0]    Y_OFF_I     = IW'(Y_OFF);
    localparam logic signed [POS_W-1:0] Y_LAUNCH_FP = POS_W'(Y_LAUNCH * (2 ** FRAC_BITS));

    fruit_state_e state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic ack_n, miss_n, done_n;
    logic load, halt, step;
    logic signed [POS_W-1:0] x_pos, y_pos, x_load;
    logic signed [VW-1:0]    vx, vy, vx_mag, vx_load, vy_load;
    logic signed [IW-1:0]    x_int, y_int;
    logic unused_bits;

    assign x_load  = {1'b0, launch_x, {FRAC_BITS{1'b0}}};
    assign vx_mag  = {1'b0, launch_vx};
    assign vx_load = launch_neg ? -vx_mag : vx_mag;
    assign vy_load = -$signed({1'b0, launch_vy});
    assign x_int   = x_pos[POS_W-1:FRAC_BITS];
    assign y_int   = y_pos[POS_W-1:FRAC_BITS];

    fruit_axis #(
        .POS_W(POS_W), .VW(VW), .FRAC_BITS(FRAC_BITS),
        .ACCEL(0), .V_TERM((2 ** VEL_W) - 1), .BOUNCE(1'b1),
        .LO_PX(X_MIN + SIZE), .HI_PX(X_MAX - SIZE), .RST_PX(X_MIN)
    ) u_axis_x (
        .frame_clk(frame_clk), .Reset(Reset), .load(load), .halt(halt), .step(step),
        .load_pos(x_load), .load_vel(vx_load), .pos(x_pos), .vel(vx)
    );

    fruit_axis #(
        .POS_W(POS_W), .VW(VW), .FRAC_BITS(FRAC_BITS),
        .ACCEL(GRAVITY), .V_TERM(VY_TERM), .BOUNCE(1'b0),
        .LO_PX(0), .HI_PX(0), .RST_PX(Y_LAUNCH)
    ) u_axis_y (
        .frame_clk(frame_clk), .Reset(Reset), .load(load), .halt(halt), .step(step),
        .load_pos(Y_LAUNCH_FP), .load_vel(vy_load), .pos(y_pos), .vel(vy)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        miss_n  = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        halt    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (launch_req) begin
                    load    = 1'b1;
                    ack_n   = 1'b1;
                    state_n = FLIGHT;
                end
            end
            FLIGHT: begin
                // slice outranks the offstage check when both land on one frame
                if (slice) begin
                    halt    = 1'b1;
                    cnt_n   = CNT_W'(SLICE_FRAMES - 1);
                    state_n = SLICED;
                end else if ((y_int >= Y_OFF_I) && !vy[VW-1] && (vy != '0)) begin
                    miss_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            SLICED: begin
                if (cnt == '0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            launch_ack <= 1'b0;
            missed     <= 1'b0;
            hit_done   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            launch_ack <= ack_n;
            missed     <= miss_n;
            hit_done   <= done_n;
        end
    end

    // a non-negative IW-bit integer already fits in COORD_W bits, so only the low side clamps
    assign fruitX = x_int[IW-1] ? '0 : x_int[COORD_W-1:0];
    assign fruitY = y_int[IW-1] ? '0 : y_int[COORD_W-1:0];
    assign fruitS = COORD_W'(SIZE);
    assign active = (state != IDLE);
    assign sliced = (state == SLICED);

    assign unused_bits = ^{vx, x_pos[FRAC_BITS-1:0], y_pos[FRAC_BITS-1:0]};

endmodule

// File: tb/tb_fruit_projectile.sv
// Self-checking bench for fruit_projectile: directed scenarios plus randomized play,
// all compared against a frame-level behavioural model of the fruit.
module tb_fruit_projectile;

    logic       frame_clk  = 1'b0;
    logic       Reset      = 1'b1;
    logic       launch_req = 1'b0;
    logic       launch_neg = 1'b0;
    logic       slice      = 1'b0;
    logic [9:0] launch_x   = '0;
    logic [9:0] launch_vy  = '0;
    logic [9:0] launch_vx  = '0;
    logic       launch_ack, active, sliced, hit_done, missed;
    logic [9:0] fruitX, fruitY, fruitS;
    logic [34:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 idle, 1 flight, 2 sliced; positions in 1/16 px
    int m_mode = 0, m_x = 0, m_y = 8000, m_vx = 0, m_vy = 0, m_hold = 0;
    bit m_ack = 0, m_miss = 0, m_done = 0;

    fruit_projectile dut (
        .frame_clk(frame_clk), .Reset(Reset), .launch_req(launch_req),
        .launch_x(launch_x), .launch_vy(launch_vy), .launch_vx(launch_vx),
        .launch_neg(launch_neg), .slice(slice),
        .launch_ack(launch_ack), .active(active), .sliced(sliced),
        .hit_done(hit_done), .missed(missed),
        .fruitX(fruitX), .fruitY(fruitY), .fruitS(fruitS)
    );

    always #5 frame_clk = ~frame_clk;

    assign obs = {launch_ack, active, sliced, hit_done, missed, fruitX, fruitY, fruitS};

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic logic [34:0] exp_vec();
        logic [34:0] e;
        e = {m_ack, (m_mode != 0), (m_mode == 2), m_done, m_miss,
             10'(sat(m_x >>> 4)), 10'(sat(m_y >>> 4)), 10'd15};
        return e;
    endfunction

    task automatic model_edge(input bit rst, input bit req, input bit slc);
        int nx, ny;
        m_ack = 0; m_miss = 0; m_done = 0;
        if (rst) begin
            m_mode = 0; m_x = 0; m_y = 8000; m_vx = 0; m_vy = 0;
        end else if (m_mode == 0) begin
            if (req) begin
                m_x    = int'(launch_x) * 16;
                m_y    = 8000;
                m_vy   = -int'(launch_vy);
                m_vx   = launch_neg ? -int'(launch_vx) : int'(launch_vx);
                m_mode = 1;
                m_ack  = 1;
            end
        end else if (m_mode == 1) begin
            if (slc) begin
                m_vx = 0; m_vy = 0; m_hold = 8; m_mode = 2;
            end else if ((m_y >>> 4) >= 560 && m_vy > 0) begin
                m_mode = 0; m_miss = 1;
            end else begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                if ((nx >>> 4) < 15) begin
                    nx = 15 * 16; m_vx = -m_vx;
                end else if ((nx >>> 4) > 624) begin
                    nx = 624 * 16; m_vx = -m_vx;
                end
                m_x = nx; m_y = ny;
                m_vy = (m_vy + 4 > 160) ? 160 : m_vy + 4;
            end
        end else begin
            m_hold--;
            if (m_hold == 0) begin
                m_mode = 0; m_done = 1;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit req, input bit slc);
        Reset = rst; launch_req = req; slice = slc;
        model_edge(rst, req, slc);
        @(posedge frame_clk);
        #1;
        Reset = 1'b0; launch_req = 1'b0; slice = 1'b0;
    endtask

    task automatic set_launch(input int x, input int vy, input int vx, input bit neg);
        launch_x = 10'(x); launch_vy = 10'(vy); launch_vx = 10'(vx); launch_neg = neg;
    endtask

    task automatic test_reset();
        set_launch(100, 50, 5, 0);
        tick(1, 1, 0);
        n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_vec: got %h want %h", obs, exp_vec()); end
        n_cmp++;
        if ({active, sliced, launch_ack, fruitX, fruitY, fruitS} !== {3'b000, 10'd0, 10'd500, 10'd15}) begin
            n_bad++; $display("FAIL reset_vals: got X=%0d Y=%0d S=%0d act=%b want X=0 Y=500 S=15 act=0", fruitX, fruitY, fruitS, active);
        end
    endtask

    task automatic test_launch();
        int wy[3] = '{500, 492, 484};
        int wx[3] = '{320, 321, 322};
        tick(1, 0, 0);
        set_launch(320, 128, 16, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(0, 0, 0);
            n_cmp++;
            if (launch_ack !== (i == 0) || fruitY !== 10'(wy[i]) || fruitX !== 10'(wx[i])) begin
                n_bad++; $display("FAIL launch_frame%0d: got ack=%b X=%0d Y=%0d want ack=%0d X=%0d Y=%0d", i, launch_ack, fruitX, fruitY, (i == 0), wx[i], wy[i]);
            end
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL launch_vec%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_apex_miss();
        int p, v, want_apex, ymin, miss_at;
        p = 8000; v = -128;
        for (int k = 0; k < 32; k++) begin
            p += v; v += 4;
        end
        want_apex = p >>> 4;
        ymin = 1023; miss_at = -1;
        tick(1, 0, 0);
        set_launch(320, 128, 16, 0);
        tick(0, 1, 0);
        for (int i = 1; i <= 200; i++) begin
            tick(0, 0, 0);
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL flight_vec%0d: got %h want %h", i, obs, exp_vec()); end
            if (int'(fruitY) < ymin) ymin = int'(fruitY);
            if (i == 32) begin
                n_cmp++; if (int'(fruitY) != want_apex) begin n_bad++; $display("FAIL apex_y: got %0d want %0d", fruitY, want_apex); end
            end
            if (missed === 1'b1) begin
                miss_at = i;
                n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL miss_active: got %b want 0", active); end
                break;
            end
        end
        n_cmp++; if (miss_at < 0) begin n_bad++; $display("FAIL miss_timeout: got no missed pulse want one within 200 frames"); end
        n_cmp++; if (ymin != want_apex) begin n_bad++; $display("FAIL apex_min: got %0d want %0d", ymin, want_apex); end
        tick(0, 0, 0);
        n_cmp++; if (missed !== 1'b0 || active !== 1'b0) begin n_bad++; $display("FAIL miss_pulse_len: got missed=%b active=%b want 0 0", missed, active); end
    endtask

    task automatic test_wall();
        int wr[4] = '{630, 624, 620, 616};
        int wl[4] = '{17, 15, 19, 23};
        tick(1, 0, 0);
        set_launch(630, 64, 64, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(0, 0, 0);
            n_cmp++; if (fruitX !== 10'(wr[i])) begin n_bad++; $display("FAIL wall_right%0d: got %0d want %0d", i, fruitX, wr[i]); end
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL wall_right_vec%0d: got %h want %h", i, obs, exp_vec()); end
        end
        tick(1, 0, 0);
        set_launch(17, 64, 64, 1);
        tick(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(0, 0, 0);
            n_cmp++; if (fruitX !== 10'(wl[i])) begin n_bad++; $display("FAIL wall_left%0d: got %0d want %0d", i, fruitX, wl[i]); end
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL wall_left_vec%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_slice_collision();
        bit found;
        int done_at;
        found = 0; done_at = -1;
        tick(1, 0, 0);
        set_launch(320, 128, 16, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            if (m_mode == 1 && (m_y >>> 4) >= 560 && m_vy > 0) begin
                found = 1; break;
            end
            tick(0, 0, 0);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL offstage_timeout: got no offstage frame want one within 300"); end
        tick(0, 0, 1);
        n_cmp++; if ({sliced, missed, active} !== 3'b101) begin n_bad++; $display("FAIL slice_prio: got sliced=%b missed=%b active=%b want 1 0 1", sliced, missed, active); end
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, (i == 3));
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL slice_vec%0d: got %h want %h", i, obs, exp_vec()); end
            if (hit_done === 1'b1) begin
                done_at = i; break;
            end
        end
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL hit_done_delay: got %0d want 8", done_at); end
        n_cmp++; if (active !== 1'b0 || sliced !== 1'b0) begin n_bad++; $display("FAIL hit_done_idle: got active=%b sliced=%b want 0 0", active, sliced); end
        set_launch(200, 40, 8, 0);
        tick(0, 1, 0);
        n_cmp++; if (launch_ack !== 1'b1 || fruitX !== 10'd200) begin n_bad++; $display("FAIL relaunch: got ack=%b X=%0d want 1 200", launch_ack, fruitX); end
    endtask

    task automatic test_ignored();
        tick(1, 0, 0);
        set_launch(320, 128, 16, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            launch_x = 10'd50;
            tick(0, 1, 0);
            n_cmp++; if ({launch_ack, active, sliced} !== 3'b010) begin n_bad++; $display("FAIL req_in_flight%0d: got ack=%b act=%b sl=%b want 0 1 0", i, launch_ack, active, sliced); end
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL req_in_flight_vec%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0);
        set_launch(320, 128, 16, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        n_cmp++;
        if ({active, sliced, missed, hit_done, launch_ack, fruitX, fruitY} !== {5'b0, 10'd0, 10'd500}) begin
            n_bad++; $display("FAIL reset_flight: got %h want act/sl/pulses 0 X=0 Y=500", obs);
        end
        tick(0, 1, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        n_cmp++;
        if ({active, sliced, missed, hit_done, launch_ack, fruitX, fruitY} !== {5'b0, 10'd0, 10'd500}) begin
            n_bad++; $display("FAIL reset_sliced: got %h want act/sl/pulses 0 X=0 Y=500", obs);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0);
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_quiet%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        bit rq, sl, rs;
        tick(1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            set_launch($urandom_range(0, 900), $urandom_range(0, 300), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            rq = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 299) == 0);
            tick(rs, rq, sl);
            n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL random%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_apex_miss();
        test_wall();
        test_slice_collision();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
